// File: rtl/multicycle_control_pkg.sv
// Shared state encodings, opcodes and ALU codes
// for the multicycle RV32 control unit.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    EXEC_I    = 4'd7,
    ALU_WB    = 4'd8,
    BRANCH    = 4'd9,
    PC_INC    = 4'd10,
    HALT      = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [1:0] SRCB_B   = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

endpackage

// File: rtl/multicycle_control_alu_control.sv
// funct3/funct7_5 to ALU operation code.
// r_type=0 masks funct7_5 so addi never becomes SUB.
module alu_control
  import multicycle_control_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       r_type,
  output logic [3:0] alu_code
);

  always_comb begin
    alu_code = ALU_ADD;
    unique case (1'b1)
      funct3 == 3'b111: alu_code = ALU_AND;
      funct3 == 3'b110: alu_code = ALU_OR;
      funct3 == 3'b000: alu_code = (r_type && funct7_5) ? ALU_SUB : ALU_ADD;
      default:          alu_code = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32 control FSM: one control vector per cycle,
// PC updated in each instruction's last state.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int STATE_W        = 4,
  parameter bit ILLEGAL_AS_NOP = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               funct7_5,
  input  logic               zero,
  output logic               PCWrite,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               PCSource,
  output logic [3:0]         ALUControl,
  output logic [STATE_W-1:0] state_o,
  output logic               instr_done
);

  state_t     state, state_n;
  logic       pc_wr, iord, mem_rd, mem_wr, ir_wr;
  logic       m2r, reg_wr, src_a, pc_src, done;
  logic [1:0] src_b;
  logic [3:0] alu_ctl, alu_fn;

  alu_control u_alu_control (
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .r_type   (state == EXEC_R),
    .alu_code (alu_fn)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FETCH;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      FETCH:  state_n = DECODE;
      DECODE: begin
        unique case (opcode)
          OP_LW, OP_SW: state_n = MEM_ADDR;
          OP_R:         state_n = EXEC_R;
          OP_I:         state_n = EXEC_I;
          OP_BEQ:       state_n = BRANCH;
          default:      state_n = ILLEGAL_AS_NOP ? PC_INC : HALT;
        endcase
      end
      MEM_ADDR:  state_n = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      MEM_READ:  state_n = MEM_WB;
      MEM_WB:    state_n = FETCH;
      MEM_WRITE: state_n = FETCH;
      EXEC_R:    state_n = ALU_WB;
      EXEC_I:    state_n = ALU_WB;
      ALU_WB:    state_n = FETCH;
      BRANCH:    state_n = zero ? FETCH : PC_INC;
      PC_INC:    state_n = FETCH;
      HALT:      state_n = HALT;
      default:   state_n = FETCH;
    endcase
  end

  always_comb begin
    pc_wr   = 1'b0;
    iord    = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    ir_wr   = 1'b0;
    m2r     = 1'b0;
    reg_wr  = 1'b0;
    src_a   = 1'b0;
    src_b   = SRCB_B;
    pc_src  = 1'b0;
    alu_ctl = ALU_ADD;
    done    = 1'b0;
    unique case (state)
      FETCH: begin
        mem_rd = 1'b1;
        ir_wr  = 1'b1;
      end
      DECODE: src_b = SRCB_IMM;
      MEM_ADDR: begin
        src_a = 1'b1;
        src_b = SRCB_IMM;
      end
      MEM_READ: begin
        iord   = 1'b1;
        mem_rd = 1'b1;
      end
      MEM_WB: begin
        m2r    = 1'b1;
        reg_wr = 1'b1;
        src_b  = SRCB_4;
        pc_wr  = 1'b1;
        done   = 1'b1;
      end
      MEM_WRITE: begin
        iord   = 1'b1;
        mem_wr = 1'b1;
        src_b  = SRCB_4;
        pc_wr  = 1'b1;
        done   = 1'b1;
      end
      EXEC_R: begin
        src_a   = 1'b1;
        alu_ctl = alu_fn;
      end
      EXEC_I: begin
        src_a   = 1'b1;
        src_b   = SRCB_IMM;
        alu_ctl = alu_fn;
      end
      ALU_WB: begin
        reg_wr = 1'b1;
        src_b  = SRCB_4;
        pc_wr  = 1'b1;
        done   = 1'b1;
      end
      // Branch target was parked in ALUOut during DECODE
      BRANCH: begin
        src_a   = 1'b1;
        alu_ctl = ALU_SUB;
        pc_src  = 1'b1;
        pc_wr   = zero;
        done    = zero;
      end
      PC_INC: begin
        src_b = SRCB_4;
        pc_wr = 1'b1;
        done  = 1'b1;
      end
      HALT:    alu_ctl = ALU_AND;
      default: alu_ctl = ALU_ADD;
    endcase
  end

  // Reset masks every strobe, including the fetch reads
  assign PCWrite    = reset_n & pc_wr;
  assign IorD       = reset_n & iord;
  assign MemRead    = reset_n & mem_rd;
  assign MemWrite   = reset_n & mem_wr;
  assign IRWrite    = reset_n & ir_wr;
  assign MemtoReg   = reset_n & m2r;
  assign RegWrite   = reset_n & reg_wr;
  assign ALUSrcA    = reset_n & src_a;
  assign ALUSrcB    = reset_n ? src_b : 2'b00;
  assign PCSource   = reset_n & pc_src;
  assign ALUControl = reset_n ? alu_ctl : 4'b0000;
  assign instr_done = reset_n & done;
  assign state_o    = reset_n ? STATE_W'(state) : STATE_W'(FETCH);

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: one expected
// control vector per cycle, queued per instruction.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7_5 = 1'b0;
  logic       zero = 1'b0;

  logic       pcw0, iord0, mr0, mw0, irw0, m2r0, rw0, sa0, pcs0, dn0;
  logic [1:0] sb0;
  logic [3:0] ac0, st0;
  logic       pcw1, iord1, mr1, mw1, irw1, m2r1, rw1, sa1, pcs1, dn1;
  logic [1:0] sb1;
  logic [3:0] ac1, st1;
  logic [19:0] v0, v1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f75;
    logic       z;
    logic [19:0] exp;
  } ent_t;

  ent_t q[$];

  always #5 clk = ~clk;

  multicycle_control #(.STATE_W(4), .ILLEGAL_AS_NOP(1'b1)) dut_nop (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct3(funct3),
    .funct7_5(funct7_5), .zero(zero), .PCWrite(pcw0), .IorD(iord0),
    .MemRead(mr0), .MemWrite(mw0), .IRWrite(irw0), .MemtoReg(m2r0),
    .RegWrite(rw0), .ALUSrcA(sa0), .ALUSrcB(sb0), .PCSource(pcs0),
    .ALUControl(ac0), .state_o(st0), .instr_done(dn0)
  );

  multicycle_control #(.STATE_W(4), .ILLEGAL_AS_NOP(1'b0)) dut_halt (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct3(funct3),
    .funct7_5(funct7_5), .zero(zero), .PCWrite(pcw1), .IorD(iord1),
    .MemRead(mr1), .MemWrite(mw1), .IRWrite(irw1), .MemtoReg(m2r1),
    .RegWrite(rw1), .ALUSrcA(sa1), .ALUSrcB(sb1), .PCSource(pcs1),
    .ALUControl(ac1), .state_o(st1), .instr_done(dn1)
  );

  assign v0 = {pcw0, iord0, mr0, mw0, irw0, m2r0, rw0, sa0,
               sb0, pcs0, ac0, dn0, st0};
  assign v1 = {pcw1, iord1, mr1, mw1, irw1, m2r1, rw1, sa1,
               sb1, pcs1, ac1, dn1, st1};

  function automatic logic [19:0] exp_vec(input logic [3:0] st,
                                          input logic z,
                                          input logic [3:0] alu);
    logic pcw, iord, mr, mw, irw, m2r, rw, sa, pcs, dn;
    logic [1:0] sb;
    logic [3:0] ac;
    {pcw, iord, mr, mw, irw, m2r, rw, sa, pcs, dn} = '0;
    sb = 2'b00;
    ac = 4'b0010;
    case (st)
      4'd0:  begin mr = 1; irw = 1; end
      4'd1:  sb = 2'b10;
      4'd2:  begin sa = 1; sb = 2'b10; end
      4'd3:  begin iord = 1; mr = 1; end
      4'd4:  begin m2r = 1; rw = 1; sb = 2'b01; pcw = 1; dn = 1; end
      4'd5:  begin iord = 1; mw = 1; sb = 2'b01; pcw = 1; dn = 1; end
      4'd6:  begin sa = 1; ac = alu; end
      4'd7:  begin sa = 1; sb = 2'b10; ac = alu; end
      4'd8:  begin rw = 1; sb = 2'b01; pcw = 1; dn = 1; end
      4'd9:  begin sa = 1; ac = 4'b0110; pcs = 1; pcw = z; dn = z; end
      4'd10: begin sb = 2'b01; pcw = 1; dn = 1; end
      4'd11: ac = 4'b0000;
      default: ac = 4'b0010;
    endcase
    return {pcw, iord, mr, mw, irw, m2r, rw, sa, sb, pcs, ac, dn, st};
  endfunction

  function automatic logic [3:0] exp_alu(input logic [2:0] f3,
                                         input logic f75,
                                         input logic is_r);
    if (f3 == 3'b111) return 4'b0000;
    if (f3 == 3'b110) return 4'b0001;
    if (f3 == 3'b000 && is_r && f75) return 4'b0110;
    return 4'b0010;
  endfunction

  task automatic push(input string tag, input logic [6:0] op,
                      input logic [2:0] f3, input logic f75,
                      input logic z, input logic [3:0] st,
                      input logic [3:0] alu);
    ent_t e;
    e.tag = tag;
    e.op  = op;
    e.f3  = f3;
    e.f75 = f75;
    e.z   = z;
    e.exp = exp_vec(st, z, alu);
    q.push_back(e);
  endtask

  task automatic push_instr(input string tag, input logic [6:0] op,
                            input logic [2:0] f3, input logic f75,
                            input logic z, input bit nop);
    push(tag, op, f3, f75, z, 4'd0, 4'd0);
    push(tag, op, f3, f75, z, 4'd1, 4'd0);
    case (op)
      7'b0000011: begin
        push(tag, op, f3, f75, z, 4'd2, 4'd0);
        push(tag, op, f3, f75, z, 4'd3, 4'd0);
        push(tag, op, f3, f75, z, 4'd4, 4'd0);
      end
      7'b0100011: begin
        push(tag, op, f3, f75, z, 4'd2, 4'd0);
        push(tag, op, f3, f75, z, 4'd5, 4'd0);
      end
      7'b0110011: begin
        push(tag, op, f3, f75, z, 4'd6, exp_alu(f3, f75, 1'b1));
        push(tag, op, f3, f75, z, 4'd8, 4'd0);
      end
      7'b0010011: begin
        push(tag, op, f3, f75, z, 4'd7, exp_alu(f3, f75, 1'b0));
        push(tag, op, f3, f75, z, 4'd8, 4'd0);
      end
      7'b1100011: begin
        push(tag, op, f3, f75, z, 4'd9, 4'd0);
        if (!z) push(tag, op, f3, f75, z, 4'd10, 4'd0);
      end
      default:
        push(tag, op, f3, f75, z, nop ? 4'd10 : 4'd11, 4'd0);
    endcase
  endtask

  task automatic drain(input int n, input bit sel);
    ent_t e;
    logic [19:0] got;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      e = q.pop_front();
      @(negedge clk);
      opcode   = e.op;
      funct3   = e.f3;
      funct7_5 = e.f75;
      zero     = e.z;
      #1;
      got = sel ? v1 : v0;
      checks++;
      if (got !== e.exp) begin
        failures++;
        $display("FAIL %s: got ctrl/state %h expected %h (time %0t)",
                 e.tag, got, e.exp, $time);
      end
    end
  endtask

  task automatic check_vec(input string tag, input logic [19:0] got,
                           input logic [19:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    check_vec("reset_outputs_nop", v0, 20'h0);
    check_vec("reset_outputs_halt", v1, 20'h0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    #1;
    check_vec("release_fetch", v0, exp_vec(4'd0, 1'b0, 4'd0));
  endtask

  task automatic test_addi();
    push_instr("addi", 7'b0010011, 3'b000, 1'b0, 1'b0, 1'b1);
    push_instr("addi_f75", 7'b0010011, 3'b000, 1'b1, 1'b0, 1'b1);
    push_instr("ori", 7'b0010011, 3'b110, 1'b0, 1'b0, 1'b1);
    drain(999, 1'b0);
  endtask

  task automatic test_lw_sw();
    push_instr("lw", 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b1);
    push_instr("sw", 7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1);
    drain(999, 1'b0);
  endtask

  task automatic test_rtype();
    push_instr("r_sub", 7'b0110011, 3'b000, 1'b1, 1'b0, 1'b1);
    push_instr("r_and", 7'b0110011, 3'b111, 1'b0, 1'b0, 1'b1);
    push_instr("r_or", 7'b0110011, 3'b110, 1'b0, 1'b0, 1'b1);
    push_instr("r_add", 7'b0110011, 3'b000, 1'b0, 1'b0, 1'b1);
    push_instr("r_other", 7'b0110011, 3'b100, 1'b1, 1'b0, 1'b1);
    drain(999, 1'b0);
  endtask

  task automatic test_beq();
    push_instr("beq_taken", 7'b1100011, 3'b000, 1'b0, 1'b1, 1'b1);
    push_instr("beq_not", 7'b1100011, 3'b000, 1'b0, 1'b0, 1'b1);
    drain(999, 1'b0);
  endtask

  task automatic test_illegal_nop();
    push_instr("illegal_nop", 7'h7F, 3'b000, 1'b0, 1'b0, 1'b1);
    push_instr("after_nop", 7'b0010011, 3'b000, 1'b0, 1'b0, 1'b1);
    drain(999, 1'b0);
  endtask

  task automatic test_reset_mid();
    push_instr("mid_r", 7'b0110011, 3'b000, 1'b1, 1'b0, 1'b1);
    drain(3, 1'b0);
    q.delete();
    reset_n = 1'b0;
    #1;
    check_vec("mid_reset_now", v0, 20'h0);
    @(posedge clk);
    #1;
    check_vec("mid_reset_held", v0, 20'h0);
    #1 reset_n = 1'b1;
    #1;
    check_vec("mid_release_fetch", v0, exp_vec(4'd0, 1'b0, 4'd0));
    push_instr("post_reset_r", 7'b0110011, 3'b111, 1'b0, 1'b0, 1'b1);
    drain(999, 1'b0);
  endtask

  task automatic test_back_to_back();
    push_instr("b2b_lw", 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b1);
    push_instr("b2b_beq", 7'b1100011, 3'b000, 1'b0, 1'b0, 1'b1);
    push_instr("b2b_sw", 7'b0100011, 3'b010, 1'b0, 1'b1, 1'b1);
    push_instr("b2b_beqt", 7'b1100011, 3'b000, 1'b0, 1'b1, 1'b1);
    push_instr("b2b_sub", 7'b0110011, 3'b000, 1'b1, 1'b1, 1'b1);
    drain(999, 1'b0);
  endtask

  task automatic test_halt();
    pulse_reset();
    push_instr("halt_entry", 7'h7F, 3'b000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      push("halt_hold", 7'b0010011, 3'b000, 1'b0, i[0], 4'd11, 4'd0);
    drain(999, 1'b1);
    pulse_reset();
    #1;
    check_vec("halt_exit_reset", v1, exp_vec(4'd0, 1'b0, 4'd0));
    push_instr("halt_after", 7'b0010011, 3'b111, 1'b0, 1'b0, 1'b0);
    drain(999, 1'b1);
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lw_sw();
    test_rtype();
    test_beq();
    test_illegal_nop();
    test_reset_mid();
    test_back_to_back();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
